// File: rtl/arbitro_matriz.sv
// arbitro_matriz: sole owner of the 60x80 light-cycle grid, time-multiplexed between VGA and two players.
// Optional ROUND_ROBIN_EN selects round-robin tie-breaking; undefined gives fixed priority to player 1.
module arbitro_matriz #(
  parameter int LINHAS  = 60,
  parameter int COLUNAS = 80,
  parameter int BORDA   = 2,
  parameter int SHIFT   = 3
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       reiniciar,
  input  logic [9:0] next_x,
  input  logic [9:0] next_y,
  output logic [1:0] saida_vga,
  input  logic       req_j1,
  input  logic [5:0] linha_j1,
  input  logic [6:0] coluna_j1,
  output logic       ack_j1,
  output logic       colisao_j1,
  input  logic       req_j2,
  input  logic [5:0] linha_j2,
  input  logic [6:0] coluna_j2,
  output logic       ack_j2,
  output logic       colisao_j2,
  output logic       limpando
);

  localparam int NCELULAS = LINHAS * COLUNAS;
  localparam int AW       = $clog2(NCELULAS);

  localparam logic [1:0] CEL_VAZIA = 2'd0;
  localparam logic [1:0] CEL_J1    = 2'd1;
  localparam logic [1:0] CEL_BORDA = 2'd2;
  localparam logic [1:0] CEL_J2    = 2'd3;

  typedef enum logic [1:0] {
    LIMPA    = 2'd0,
    OCIOSO   = 2'd1,
    VERIFICA = 2'd2
  } estado_t;

  function automatic logic dentro(input logic [9:0] l, input logic [9:0] c);
    return (l < 10'(LINHAS)) && (c < 10'(COLUNAS));
  endfunction

  function automatic logic [AW-1:0] endereco(input logic [9:0] l, input logic [9:0] c);
    logic [19:0] t;
    t = 20'(l) * 20'(COLUNAS) + 20'(c);
    return t[AW-1:0];
  endfunction

  function automatic logic [1:0] valor_limpeza(input logic [9:0] l, input logic [9:0] c);
    logic borda;
    borda = (l < 10'(BORDA)) || (l >= 10'(LINHAS - BORDA)) ||
            (c < 10'(BORDA)) || (c >= 10'(COLUNAS - BORDA));
    return borda ? CEL_BORDA : CEL_VAZIA;
  endfunction

  logic [1:0]    mem_r [0:NCELULAS-1];

  estado_t       estado_r;
  logic          fase_r;
  logic [5:0]    lin_lz_r;
  logic [6:0]    col_lz_r;
  logic [5:0]    lat_lin_r;
  logic [6:0]    lat_col_r;
  logic          lat_j2_r;
  logic [1:0]    saida_r;
  logic          ack1_r;
  logic          ack2_r;
  logic          col1_r;
  logic          col2_r;
  logic          limpando_r;
`ifdef ROUND_ROBIN_EN
  logic          rr_r;
`endif

  logic [9:0]    vga_lin_s;
  logic [9:0]    vga_col_s;
  logic          vga_ok_s;
  logic          lat_ok_s;
  logic [AW-1:0] rd_addr_s;
  logic [1:0]    rd_data_s;
  logic          livre_s;
  logic          gnt_j1_s;
  logic          gnt_j2_s;
  logic          we_s;
  logic [AW-1:0] wa_s;
  logic [1:0]    wd_s;

  assign vga_lin_s = next_y >> SHIFT;
  assign vga_col_s = next_x >> SHIFT;
  assign vga_ok_s  = dentro(vga_lin_s, vga_col_s);
  assign lat_ok_s  = dentro({4'd0, lat_lin_r}, {3'd0, lat_col_r});

  // Read port: VGA owns the even slot, the latched player cell the odd slot
  always_comb begin
    rd_addr_s = {AW{1'b0}};
    if (!fase_r) begin
      rd_addr_s = vga_ok_s ? endereco(vga_lin_s, vga_col_s) : {AW{1'b0}};
    end else begin
      rd_addr_s = lat_ok_s ? endereco({4'd0, lat_lin_r}, {3'd0, lat_col_r}) : {AW{1'b0}};
    end
  end

  assign rd_data_s = mem_r[rd_addr_s];
  assign livre_s   = lat_ok_s && (rd_data_s == CEL_VAZIA);

  // Arbitration between simultaneous move requests
  always_comb begin
    gnt_j1_s = 1'b0;
    gnt_j2_s = 1'b0;
`ifdef ROUND_ROBIN_EN
    gnt_j1_s = req_j1 && (!req_j2 || !rr_r);
`else
    gnt_j1_s = req_j1;
`endif
    gnt_j2_s = req_j2 && !gnt_j1_s;
  end

  // Write port: sweep writes every clock, a player test-and-set writes only into an empty cell
  always_comb begin
    we_s = 1'b0;
    wa_s = {AW{1'b0}};
    wd_s = CEL_VAZIA;
    if (reiniciar) begin
      we_s = 1'b0;
    end else if (estado_r == LIMPA) begin
      we_s = 1'b1;
      wa_s = endereco({4'd0, lin_lz_r}, {3'd0, col_lz_r});
      wd_s = valor_limpeza({4'd0, lin_lz_r}, {3'd0, col_lz_r});
    end else if ((estado_r == VERIFICA) && fase_r && livre_s) begin
      we_s = 1'b1;
      wa_s = rd_addr_s;
      wd_s = lat_j2_r ? CEL_J2 : CEL_J1;
    end else begin
      we_s = 1'b0;
    end
  end

  // Grid storage
  always_ff @(posedge CLOCK_50) begin
    if (we_s) begin
      mem_r[wa_s] <= wd_s;
    end
  end

  // Slot phase, clear sweep, player FSM and registered outputs
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      fase_r     <= 1'b0;
      estado_r   <= LIMPA;
      lin_lz_r   <= 6'd0;
      col_lz_r   <= 7'd0;
      lat_lin_r  <= 6'd0;
      lat_col_r  <= 7'd0;
      lat_j2_r   <= 1'b0;
      saida_r    <= CEL_VAZIA;
      ack1_r     <= 1'b0;
      ack2_r     <= 1'b0;
      col1_r     <= 1'b0;
      col2_r     <= 1'b0;
      limpando_r <= 1'b1;
`ifdef ROUND_ROBIN_EN
      rr_r       <= 1'b0;
`endif
    end else begin
      fase_r <= ~fase_r;
      ack1_r <= 1'b0;
      ack2_r <= 1'b0;
      col1_r <= 1'b0;
      col2_r <= 1'b0;
      if (reiniciar) begin
        // a pending check is dropped without acknowledging it
        estado_r   <= LIMPA;
        lin_lz_r   <= 6'd0;
        col_lz_r   <= 7'd0;
        limpando_r <= 1'b1;
        saida_r    <= CEL_VAZIA;
      end else begin
        if (estado_r == LIMPA) begin
          saida_r <= CEL_VAZIA;
        end else if (!fase_r) begin
          saida_r <= vga_ok_s ? rd_data_s : CEL_VAZIA;
        end
        case (estado_r)
          LIMPA: begin
            if (col_lz_r == 7'(COLUNAS - 1)) begin
              col_lz_r <= 7'd0;
              if (lin_lz_r == 6'(LINHAS - 1)) begin
                lin_lz_r   <= 6'd0;
                limpando_r <= 1'b0;
                estado_r   <= OCIOSO;
              end else begin
                lin_lz_r <= lin_lz_r + 6'd1;
              end
            end else begin
              col_lz_r <= col_lz_r + 7'd1;
            end
          end
          OCIOSO: begin
            if (fase_r && (gnt_j1_s || gnt_j2_s)) begin
              lat_lin_r <= gnt_j1_s ? linha_j1  : linha_j2;
              lat_col_r <= gnt_j1_s ? coluna_j1 : coluna_j2;
              lat_j2_r  <= gnt_j2_s;
              estado_r  <= VERIFICA;
            end
          end
          VERIFICA: begin
            if (fase_r) begin
              if (lat_j2_r) begin
                ack2_r <= 1'b1;
                col2_r <= ~livre_s;
              end else begin
                ack1_r <= 1'b1;
                col1_r <= ~livre_s;
              end
`ifdef ROUND_ROBIN_EN
              rr_r <= ~lat_j2_r;
`endif
              estado_r <= OCIOSO;
            end
          end
          default: begin
            estado_r   <= LIMPA;
            lin_lz_r   <= 6'd0;
            col_lz_r   <= 7'd0;
            limpando_r <= 1'b1;
          end
        endcase
      end
    end
  end

  assign saida_vga  = saida_r;
  assign ack_j1     = ack1_r;
  assign ack_j2     = ack2_r;
  assign colisao_j1 = col1_r;
  assign colisao_j2 = col2_r;
  assign limpando   = limpando_r;

endmodule
